regfile_multiport: RTL and testbench

//   Parametrised successor to the lab register file: DEPTH x DATA_W storage, NUM_RD read ports, one write port.

---
 rtl/regfile_multiport.sv | 62 ++++++
 tb/tb_regfile_multiport.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x DATA_W register file with NUM_RD read ports, one write port, optional zero entry, bypass and registered read
// clk: rising-edge clock; reset: async active-low; rg_wrt_en/rg_wrt_addr/rg_wrt_data: write port
// rg_rd_addr/rg_rd_data/rg_rd_valid: packed read ports, port k in slice k; valid = entry written since reset
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_LAT   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rg_wrt_en,
  input  logic [ADDR_W-1:0]        rg_wrt_addr,
  input  logic [DATA_W-1:0]        rg_wrt_data,
  input  logic [NUM_RD*ADDR_W-1:0] rg_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rg_rd_data,
  output logic [NUM_RD-1:0]        rg_rd_valid
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0] written;
  logic wr_ok;
  // a write that actually lands: gated by reset so a write in a reset cycle is dropped and never bypassed
  assign wr_ok = reset && rg_wrt_en && !(ZERO_REG != 0 && rg_wrt_addr == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem     <= '0;
      written <= '0;
    end else if (wr_ok) begin
      mem[rg_wrt_addr]     <= rg_wrt_data;
      written[rg_wrt_addr] <= 1'b1;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic zero, byp, v;
    assign a    = rg_rd_addr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && a == '0;
    assign byp  = BYPASS != 0 && wr_ok && a == rg_wrt_addr;
    assign d    = (!reset || zero) ? '0 : byp ? rg_wrt_data : mem[a];
    assign v    = zero || (reset && (byp || written[a]));
    if (RD_LAT != 0) begin : g_reg
      logic [DATA_W-1:0] d_q;
      logic v_q;
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else begin
          d_q <= d;
          v_q <= v;
        end
      assign rg_rd_data[k*DATA_W +: DATA_W] = d_q;
      assign rg_rd_valid[k]                 = v_q;
    end else begin : g_comb
      assign rg_rd_data[k*DATA_W +: DATA_W] = d;
      assign rg_rd_valid[k]                 = v;
    end
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard bench for a combinational/bypass/zero-entry instance and a registered/no-bypass instance
module tb_regfile_multiport;
  logic clk = 1'b0;
  logic reset;
  logic wen;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic [9:0] raddr;
  logic [63:0] da, db;
  logic [1:0] va, vb;
  int checks = 0;
  int failures = 0;
  logic [65:0] qa[$];
  logic [65:0] qb[$];
  logic [31:0] ma[32];
  logic [31:0] mb[32];
  logic [31:0] fa, fb;
  logic [65:0] prev_b;

  always #10 clk = ~clk;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .RD_LAT(0)) dut_a (
    .clk(clk), .reset(reset), .rg_wrt_en(wen), .rg_wrt_addr(waddr), .rg_wrt_data(wdata),
    .rg_rd_addr(raddr), .rg_rd_data(da), .rg_rd_valid(va));

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .rg_wrt_en(wen), .rg_wrt_addr(waddr), .rg_wrt_data(wdata),
    .rg_rd_addr(raddr), .rg_rd_data(db), .rg_rd_valid(vb));

  always @(negedge clk) begin
    logic [65:0] e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      checks++;
      if ({va, da} !== e) begin
        failures++;
        $display("FAIL comb_bypass_read addr=%h got=%h expected=%h", raddr, {va, da}, e);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      checks++;
      if ({vb, db} !== e) begin
        failures++;
        $display("FAIL registered_read addr=%h got=%h expected=%h", raddr, {vb, db}, e);
      end
    end
  end

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r0, input logic [4:0] r1);
    logic [31:0] ed[2];
    logic ev[2];
    logic [4:0] ra[2];
    @(posedge clk);
    #1;
    reset = r;
    wen = we;
    waddr = wa;
    wdata = wd;
    raddr = {r1, r0};
    ra[0] = r0;
    ra[1] = r1;
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 0;
        mb[i] = 0;
      end
      fa = 0;
      fb = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (ra[k] == 0) begin
        ed[k] = 0;
        ev[k] = 1'b1;
      end else if (r && we && wa == ra[k]) begin
        ed[k] = wd;
        ev[k] = 1'b1;
      end else begin
        ed[k] = ma[ra[k]];
        ev[k] = fa[ra[k]];
      end
    end
    qa.push_back({ev[1], ev[0], ed[1], ed[0]});
    qb.push_back(r ? prev_b : 66'd0);
    prev_b = {fb[r1], fb[r0], mb[r1], mb[r0]};
    if (r && we) begin
      if (wa != 0) begin
        ma[wa] = wd;
        fa[wa] = 1'b1;
      end
      mb[wa] = wd;
      fb[wa] = 1'b1;
    end
  endtask

  function automatic logic [4:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    fa = 0;
    fb = 0;
    prev_b = 0;
    reset = 1'b1;
    wen = 1'b0;
    waddr = 0;
    wdata = 0;
    raddr = 0;
    #2 reset = 1'b0;
    step(0, 1, 1, 32'hFFFFFFFF, 1, 1);
    step(1, 1, 1, 32'hFFFFFFFF, 1, 31);
    step(1, 1, 31, 32'h12345678, 1, 31);
    step(1, 0, 0, 0, 1, 31);
    step(1, 0, 3, 32'hDEADBEEF, 3, 3);
    step(1, 1, 0, 32'hAAAAAAAA, 0, 0);
    step(1, 0, 0, 0, 0, 3);
    step(1, 1, 5, 32'hCAFEF00D, 5, 1);
    step(1, 0, 0, 0, 5, 31);
    step(1, 0, 0, 0, 31, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 1, 7, 32'h11111111, 1, 31);
    step(1, 0, 0, 0, 1, 31);
    step(1, 0, 0, 0, 7, 31);
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), pick_addr(), $urandom, pick_addr(), pick_addr());
    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", qa.size() + qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
